ebr_initval_reader: RTL and testbench

// - Reads back the contents of one EBR_CORE instance through its read port and packs

---
 rtl/ebr_initval_reader.sv | 162 ++++++++++++++++
 tb/tb_ebr_initval_reader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ebr_initval_reader.sv
// ebr_initval_reader
// Reads back every word of one EBR_CORE through its read port and packs the
// words into INITVAL rows: 64 rows of 16 words, each word zero-padded to 20 bits.
// Optional build macro: EBR_OUTREG_EN (the EBR output register is enabled, so
// the read latency grows from one to two cycles).

module ebr_initval_reader #(
    parameter int DATA_W    = 18,
    parameter int ADDR_W    = 10,
    parameter int ROW_WORDS = 16,
    parameter int PAD_W     = 2,
    parameter int IDX_W     = ADDR_W - $clog2(ROW_WORDS)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    output logic                             busy,
    output logic                             done,
    output logic [ADDR_W-1:0]                ebr_addr,
    output logic                             ebr_ce,
    input  logic [DATA_W-1:0]                ebr_rdata,
    output logic                             row_valid,
    input  logic                             row_ready,
    output logic [IDX_W-1:0]                 row_idx,
    output logic [ROW_WORDS*(DATA_W+PAD_W)-1:0] row_data
);

    localparam int WORD_W = DATA_W + PAD_W;
    localparam int SLOT_W = $clog2(ROW_WORDS);
`ifdef EBR_OUTREG_EN
    localparam int RL = 2;
`else
    localparam int RL = 1;
`endif

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        EMIT,
        FIN
    } state_t;

    state_t state;
    state_t state_next;

    logic [SLOT_W-1:0] cnt;
    logic [DATA_W-1:0] row_buf [ROW_WORDS];

    logic              cap_v0;
    logic [SLOT_W-1:0] cap_slot0;
    logic              cap_v;
    logic [SLOT_W-1:0] cap_slot;
`ifdef EBR_OUTREG_EN
    logic              cap_v1;
    logic [SLOT_W-1:0] cap_slot1;
`endif

    // Next-state and Moore outputs; the sink handshake is row_ready while in EMIT
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        ebr_ce     = 1'b0;
        row_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = ISSUE;
            end
            ISSUE: begin
                busy   = 1'b1;
                ebr_ce = 1'b1;
                if (cnt == SLOT_W'(ROW_WORDS - 1)) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (cnt == SLOT_W'(RL - 1)) state_next = EMIT;
            end
            EMIT: begin
                busy      = 1'b1;
                row_valid = 1'b1;
                if (row_ready) state_next = (row_idx == '1) ? FIN : ISSUE;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Cycle counter restarts on every state change; it paces ISSUE and DRAIN
    always_ff @(posedge clk) begin
        if (rst)                      cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else                          cnt <= cnt + SLOT_W'(1);
    end

    // Read address walks up during ISSUE and parks at the top word after the last row
    always_ff @(posedge clk) begin
        if (rst) begin
            ebr_addr <= '0;
            row_idx  <= '0;
        end else begin
            if (state == IDLE && start) begin
                ebr_addr <= '0;
                row_idx  <= '0;
            end
            if (state == ISSUE && ebr_addr != '1) ebr_addr <= ebr_addr + ADDR_W'(1);
            if (state == EMIT && row_ready && row_idx != '1) row_idx <= row_idx + IDX_W'(1);
        end
    end

    // Capture pipeline delays the read strobe and slot index to line up with EBR data
    always_ff @(posedge clk) begin
        if (rst) begin
            cap_v0    <= 1'b0;
            cap_slot0 <= '0;
`ifdef EBR_OUTREG_EN
            cap_v1    <= 1'b0;
            cap_slot1 <= '0;
`endif
        end else begin
            cap_v0    <= ebr_ce;
            cap_slot0 <= ebr_addr[SLOT_W-1:0];
`ifdef EBR_OUTREG_EN
            cap_v1    <= cap_v0;
            cap_slot1 <= cap_slot0;
`endif
        end
    end

`ifdef EBR_OUTREG_EN
    assign cap_v    = cap_v1;
    assign cap_slot = cap_slot1;
`else
    assign cap_v    = cap_v0;
    assign cap_slot = cap_slot0;
`endif

    // Row buffer; nothing is written in EMIT so the presented row stays stable
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < ROW_WORDS; k++) row_buf[k] <= '0;
        end else if (cap_v) begin
            row_buf[cap_slot] <= ebr_rdata;
        end
    end

    // Pack the buffer into INITVAL layout with zero pads above every word
    always_comb begin
        row_data = '0;
        for (int k = 0; k < ROW_WORDS; k++) row_data[k*WORD_W +: DATA_W] = row_buf[k];
    end

endmodule

// File: tb/tb_ebr_initval_reader.sv
// tb_ebr_initval_reader
// Scoreboard bench: each accepted start pushes the 64 expected rows (built from
// the EBR memory image) into a queue, and a negedge monitor pops and compares
// every row handshake. Honours EBR_OUTREG_EN for the EBR model and row period.

module tb_ebr_initval_reader;

   localparam int ROWS  = 64;
   localparam int WORDS = 16;
`ifdef EBR_OUTREG_EN
   localparam int PERIOD = 19;
`else
   localparam int PERIOD = 18;
`endif

   typedef struct {
      logic [5:0]   idx;
      logic [319:0] data;
   } row_t;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         busy;
   logic         done;
   logic [9:0]   ebr_addr;
   logic         ebr_ce;
   logic [17:0]  ebr_rdata;
   logic         row_valid;
   logic         row_ready;
   logic [5:0]   row_idx;
   logic [319:0] row_data;

   logic [17:0]  mem [1024];
   logic [17:0]  rdQ;
   row_t         expQ [$];

   int compared   = 0;
   int mismatched = 0;
   int cyc        = 0;
   int hsCount    = 0;
   int doneCount  = 0;
   int lastHsCyc  = -1;
   bit periodCheck = 0;
   bit expectIssue = 0;
   bit expectDone  = 0;
   int expectAddr  = 0;
   bit holdV       = 0;
   logic [5:0]   holdIdx;
   logic [319:0] holdData;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   ebr_initval_reader dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .ebr_addr  (ebr_addr),
      .ebr_ce    (ebr_ce),
      .ebr_rdata (ebr_rdata),
      .row_valid (row_valid),
      .row_ready (row_ready),
      .row_idx   (row_idx),
      .row_data  (row_data)
   );

   // EBR read port model: registered read, optional output register
   always @(posedge clk) if (ebr_ce) rdQ <= mem[ebr_addr];
`ifdef EBR_OUTREG_EN
   logic [17:0] rdQ2;
   always @(posedge clk) rdQ2 <= rdQ;
   assign ebr_rdata = rdQ2;
`else
   assign ebr_rdata = rdQ;
`endif

   // Compare small values
   task automatic checkOutput(input string nm, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Compare full rows
   task automatic checkRow(input string nm, input logic [319:0] act, input logic [319:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference row: word k of row r is memory word 16r+k, zero-padded to 20 bits
   function automatic row_t modelRow(input int r);
      row_t e;
      e.idx  = 6'(r);
      e.data = '0;
      for (int k = 0; k < WORDS; k++) e.data[20*k +: 20] = {2'b00, mem[r*WORDS + k]};
      return e;
   endfunction

   // Monitor: handshake scoreboard, hold stability, post-handshake timing
   always @(negedge clk) begin
      if (rst) begin
         holdV       = 0;
         expectIssue = 0;
         expectDone  = 0;
      end else begin
         if (expectIssue) begin
            checkOutput("issue_ce_after_hs", int'(ebr_ce), 1);
            checkOutput("issue_addr_after_hs", int'(ebr_addr), expectAddr);
            expectIssue = 0;
         end
         if (expectDone) begin
            checkOutput("done_after_last", int'(done), 1);
            checkOutput("busy_at_done", int'(busy), 0);
            expectDone = 0;
         end
         if (done) doneCount++;
         if (holdV && row_valid) begin
            checkOutput("hold_idx_stable", int'(row_idx), int'(holdIdx));
            checkRow("hold_data_stable", row_data, holdData);
         end
         holdV    = row_valid && !row_ready;
         holdIdx  = row_idx;
         holdData = row_data;
         if (row_valid && row_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("unexpected_row", int'(row_idx), -1);
            end else begin
               row_t e;
               e = expQ.pop_front();
               checkOutput("row_idx", int'(row_idx), int'(e.idx));
               checkRow("row_data", row_data, e.data);
            end
            hsCount++;
            if (periodCheck && lastHsCyc >= 0) checkOutput("row_period", cyc - lastHsCyc, PERIOD);
            lastHsCyc = cyc;
            if (row_idx != 6'd63) begin
               expectIssue = 1;
               expectAddr  = (int'(row_idx) + 1) * WORDS;
            end else begin
               expectDone = 1;
            end
         end
      end
   end

   // One readback. mode 0: ready high, period check; 1: random ready, 7-cycle
   // hold on row 5, extra start at row 10; 2: random ready, reset on row 20 EMIT;
   // 3: random ready
   task automatic applyStimulus(input int mode);
      int  budget;
      int  holdCnt;
      bit  restarted;
      bit  sawDone;
      int  hsBase;
      int  doneBase;
      hsBase      = hsCount;
      doneBase    = doneCount;
      lastHsCyc   = -1;
      periodCheck = (mode == 0);
      holdCnt     = 0;
      restarted   = 0;
      sawDone     = 0;
      @(posedge clk); #1;
      start     = 1'b1;
      row_ready = 1'b1;
      for (int r = 0; r < ROWS; r++) expQ.push_back(modelRow(r));
      @(posedge clk); #1;
      start = 1'b0;
      for (budget = 0; budget < 4000; budget++) begin
         if (done) begin
            sawDone = 1;
            break;
         end
         if (mode == 0) row_ready = 1'b1;
         else if (mode == 1 && row_valid && row_idx == 6'd5 && holdCnt < 7) begin
            row_ready = 1'b0;
            holdCnt++;
         end else row_ready = ($urandom_range(0, 2) != 0);
         if (mode == 1 && !restarted && busy && row_idx == 6'd10) begin
            start     = 1'b1;
            restarted = 1;
         end else start = 1'b0;
         if (mode == 2 && row_valid && row_idx == 6'd20) begin
            row_ready = 1'b0;
            rst       = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            checkOutput("rst_mid_row_valid", int'(row_valid), 0);
            checkOutput("rst_mid_busy", int'(busy), 0);
            checkOutput("rst_mid_addr", int'(ebr_addr), 0);
            checkOutput("rst_mid_idx", int'(row_idx), 0);
            expQ.delete();
            repeat (4) @(posedge clk);
            #1;
            checkOutput("rst_mid_no_done", doneCount - doneBase, 0);
            checkOutput("rst_mid_rows_seen", hsCount - hsBase, 20);
            return;
         end
         @(posedge clk); #1;
      end
      start     = 1'b0;
      row_ready = 1'b0;
      if (!sawDone) checkOutput("done_timeout", 0, 1);
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rows_per_run", hsCount - hsBase, ROWS);
      checkOutput("done_per_run", doneCount - doneBase, 1);
      checkOutput("queue_drained", expQ.size(), 0);
      checkOutput("busy_after_run", int'(busy), 0);
      checkOutput("addr_saturated", int'(ebr_addr), 1023);
      periodCheck = 0;
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      row_ready = 1'b0;
      for (int a = 0; a < 1024; a++) mem[a] = 18'(a);
      mem[10'h3F0] = 18'h3FFFF;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      checkOutput("reset_busy", int'(busy), 0);
      checkOutput("reset_done", int'(done), 0);
      checkOutput("reset_ce", int'(ebr_ce), 0);
      checkOutput("reset_addr", int'(ebr_addr), 0);
      checkOutput("reset_valid", int'(row_valid), 0);
      checkOutput("reset_idx", int'(row_idx), 0);
      checkRow("reset_data", row_data, 320'd0);

      $display("[TB] run 0: identity image, ready held high");
      applyStimulus(0);

      for (int a = 0; a < 1024; a++) mem[a] = 18'($urandom());
      $display("[TB] run 1: random image, backpressure, extra start");
      applyStimulus(1);

      for (int a = 0; a < 1024; a++) mem[a] = 18'($urandom());
      $display("[TB] run 2: reset during row 20");
      applyStimulus(2);
      $display("[TB] run 3: fresh start after reset");
      applyStimulus(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
